uart_frame_scheduler: RTL and testbench
=======================================

// Module: uart_frame_scheduler
//
// PURPOSE
// - Shares the single UART transmit path between NUM_CH 32-bit word producers
//   (velocity samples, status words, ...).
// - Arbitrates round-robin and wraps each granted word in a byte frame:
//   header, channel ID, 4 data bytes MSB first, optional checksum.
// - Pushes the frame one byte at a time into the UART TX FIFO, honouring tx_full.
// - Sits between the producers and uart_top (drives its data_in/i_wr_uart, reads o_full).
//
// PARAMETERS
// NUM_CH     2      number of requesters, legal 2..16
// HEADER     8'hA5  first byte of every frame
// ID_W       4      channel-index width, >= clog2(NUM_CH)
//
// PORTS
// clk        in   1          system clock (12 MHz)
// reset      in   1          synchronous, active-high
// i_req      in   NUM_CH     level request per channel, held until o_ack
// i_data     in   32*NUM_CH  word per channel; ch k at [32k+31:32k]
// o_ack      out  NUM_CH     1-cycle pulse: channel word latched
// o_busy     out  1          high while a frame is in progress (state != IDLE)
// i_tx_full  in   1          UART TX FIFO full (uart_top o_full)
// o_wr_uart  out  1          1-cycle write strobe to UART FIFO
// o_w_data   out  32         byte in [7:0]; [31:8] always 0
//
// BEHAVIOUR
// - Reset: state=IDLE, o_ack=0, o_busy=0, o_wr_uart=0, o_w_data=0, rr_ptr=NUM_CH-1,
//   csum=0. Reset mid-frame aborts it; the rest of the frame is never sent.
// - States: IDLE -> HDR -> ID -> B3 -> B2 -> B1 -> B0 -> [CSUM] -> IDLE.
// - IDLE, on an edge with |i_req:
//   - Grant g = first requesting channel searching rr_ptr+1 upward, wrapping
//     modulo NUM_CH.
//   - Latch word[g], set rr_ptr<=g, pulse o_ack[g] in the next cycle, go to HDR.
//   - A request dropped before it is granted is simply not served.
// - Byte states, on an edge with i_tx_full==0 and o_wr_uart==0:
//   - o_wr_uart<=1, o_w_data<={24'b0,byte}, advance state.
//   - Otherwise o_wr_uart<=0 and the state holds.
//   - The forced gap after each strobe lets full update, so there is never a
//     write into a full FIFO.
//   - Maximum rate: 1 byte / 2 cycles.
// - Byte values:
//   - HDR = HEADER.
//   - ID  = g zero-extended to 8 bits.
//   - B3..B0 = word[31:24]..word[7:0].
// - Latency: request seen at edge N -> o_ack high cycle N+1 -> first strobe
//   earliest at edge N+1 (HDR).
// - Frame end: last strobe moves to IDLE. IDLE lasts >= 1 cycle, so there is
//   never a grant in the same cycle as the final strobe.
// - i_data of a granted channel may change right after o_ack; the latched copy
//   is sent.
// - o_busy is high in every state except IDLE.
// - i_req/i_data changes while busy have no effect until IDLE.
//
// CONFIGURATION
// - UART_FRAME_CSUM_EN defined:
//   - CSUM state appended.
//   - Checksum byte = 8-bit sum mod 256 of HDR, ID, B3..B0.
//   - 7-byte frame.
// - UART_FRAME_CSUM_EN undefined:
//   - B0 returns directly to IDLE.
//   - 6-byte frame; no checksum logic is built.
//
// TESTING
// 1. Ch0 req, data 32'h12345678, full=0, CSUM_EN ->
//    o_w_data[7:0] seq A5 00 12 34 56 78 B9; o_ack[0] 1 pulse; strobes 2 cycles apart.
// 2. Same stimulus, CSUM_EN undefined ->
//    A5 00 12 34 56 78, then o_busy=0; exactly 6 strobes.
// 3. After reset, ch0 and ch1 req together, held ->
//    frames ch0 then ch1 (ID 00, 01).
//    Re-raise both together -> ch0 served first again (rr_ptr=1).
// 4. i_tx_full=1 for 10 cycles after B3 strobe ->
//    no strobes during stall; B2 sent on first eligible edge after full drops.
// 5. reset pulsed after B2 strobe ->
//    o_wr_uart=0 next cycle, state IDLE, o_busy=0; pending req re-served from HDR.
// 6. Ch1 req raised and dropped before grant while frame busy ->
//    no ch1 frame, no o_ack[1].

Source files
------------

// File: rtl/uart_frame_scheduler.sv
// -----------------------------------------------------------------------------
// uart_frame_scheduler
//
// Purpose:
//   Shares one UART transmit path between NUM_CH producers of 32-bit words.
//   Requests are arbitrated round-robin. Each granted word is wrapped in a byte
//   frame: HEADER, channel ID, data bytes B3..B0 (MSB first) and an optional
//   checksum byte. The frame is pushed one byte at a time into the UART TX FIFO.
//
// Optional feature (compile-time macro):
//   UART_FRAME_CSUM_EN - when defined, a checksum byte is appended after B0.
//                        The checksum is the 8-bit sum of HDR, ID and B3..B0.
//                        When undefined, B0 returns straight to IDLE and no
//                        checksum logic is built.
//
// Ports:
//   clk        in   1          system clock
//   reset      in   1          synchronous, active-high
//   i_req      in   NUM_CH     level request per channel, held until o_ack
//   i_data     in   32*NUM_CH  word per channel; channel k at [32k+31:32k]
//   o_ack      out  NUM_CH     1-cycle pulse: the channel's word was latched
//   o_busy     out  1          high while a frame is in progress
//   i_tx_full  in   1          UART TX FIFO full
//   o_wr_uart  out  1          1-cycle write strobe to the UART FIFO
//   o_w_data   out  32         byte in [7:0]; [31:8] always zero
// -----------------------------------------------------------------------------
module uart_frame_scheduler #(
  parameter int          NUM_CH = 2,
  parameter logic [7:0]  HEADER = 8'hA5,
  parameter int          ID_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      i_req,
  input  logic [32*NUM_CH-1:0]   i_data,
  output logic [NUM_CH-1:0]      o_ack,
  output logic                   o_busy,
  input  logic                   i_tx_full,
  output logic                   o_wr_uart,
  output logic [31:0]            o_w_data
);

  localparam int SEL_W = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_ID   = 3'd2,
    S_B3   = 3'd3,
    S_B2   = 3'd4,
    S_B1   = 3'd5,
    S_B0   = 3'd6,
    S_CSUM = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [31:0]         word_q, word_d;
  logic [NUM_CH-1:0]   ack_q, ack_d;
  logic                wr_q, wr_d;
  logic [7:0]          wdata_q, wdata_d;
`ifdef UART_FRAME_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  // Unpack the flat input bus into one word per channel.
  logic [31:0] ch_word [NUM_CH];
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_word[gi] = i_data[32*gi +: 32];
  end

  // Round-robin search starting just after the last granted channel.
  // The loop runs from the farthest offset down to the nearest one so that
  // the last assignment (the nearest requester) wins.
  logic             grant_valid;
  logic [SEL_W-1:0] grant_sel;

  always_comb begin
    logic [SEL_W-1:0] cand;
    grant_valid = 1'b0;
    grant_sel   = '0;
    cand        = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = SEL_W'((int'(rr_ptr_q) + off) % NUM_CH);
      if (i_req[cand]) begin
        grant_valid = 1'b1;
        grant_sel   = cand;
      end
    end
  end

  // Byte presented by the current byte state and the state that follows it.
  logic [7:0] cur_byte;
  state_t     after_byte;

  always_comb begin
    cur_byte   = 8'h00;
    after_byte = S_IDLE;
    case (state_q)
      S_HDR: begin cur_byte = HEADER;          after_byte = S_ID; end
      // rr_ptr holds the granted channel for the whole frame.
      S_ID:  begin cur_byte = 8'(rr_ptr_q);    after_byte = S_B3; end
      S_B3:  begin cur_byte = word_q[31:24];   after_byte = S_B2; end
      S_B2:  begin cur_byte = word_q[23:16];   after_byte = S_B1; end
      S_B1:  begin cur_byte = word_q[15:8];    after_byte = S_B0; end
`ifdef UART_FRAME_CSUM_EN
      S_B0:  begin cur_byte = word_q[7:0];     after_byte = S_CSUM; end
      S_CSUM: begin cur_byte = csum_q;         after_byte = S_IDLE; end
`else
      S_B0:  begin cur_byte = word_q[7:0];     after_byte = S_IDLE; end
`endif
      default: begin cur_byte = 8'h00;         after_byte = S_IDLE; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    word_d   = word_q;
    ack_d    = '0;
    wr_d     = 1'b0;
    wdata_d  = wdata_q;
`ifdef UART_FRAME_CSUM_EN
    csum_d   = csum_q;
`endif
    if (state_q == S_IDLE) begin
      if (grant_valid) begin
        word_d           = ch_word[grant_sel];
        rr_ptr_d         = ID_W'(grant_sel);
        ack_d[grant_sel] = 1'b1;
        state_d          = S_HDR;
`ifdef UART_FRAME_CSUM_EN
        csum_d           = 8'h00;
`endif
      end
    end else begin
      // A strobe is never issued on the cycle right after another one, so
      // i_tx_full has a cycle to reflect the previous write.
      if (!i_tx_full && !wr_q) begin
        wr_d    = 1'b1;
        wdata_d = cur_byte;
        state_d = after_byte;
`ifdef UART_FRAME_CSUM_EN
        csum_d  = csum_q + cur_byte;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= ID_W'(NUM_CH - 1);
      word_q   <= '0;
      ack_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= 8'h00;
`ifdef UART_FRAME_CSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      word_q   <= word_d;
      ack_q    <= ack_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
`ifdef UART_FRAME_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign o_ack     = ack_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_wr_uart = wr_q;
  assign o_w_data  = {24'h000000, wdata_q};

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_scheduler
//
// Directed bench for uart_frame_scheduler (NUM_CH = 2). A monitor records
// every write strobe (byte and cycle) and every o_ack pulse; the main sequence
// applies directed scenarios and compares the record against hand-built
// expected frames. Honours UART_FRAME_CSUM_EN for the expected frame length.
// -----------------------------------------------------------------------------
module tb_uart_frame_scheduler;

  localparam int NUM_CH = 2;
`ifdef UART_FRAME_CSUM_EN
  localparam int FLEN = 7;
`else
  localparam int FLEN = 6;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    i_req;
  logic [32*NUM_CH-1:0] i_data;
  logic [NUM_CH-1:0]    o_ack;
  logic                 o_busy;
  logic                 i_tx_full;
  logic                 o_wr_uart;
  logic [31:0]          o_w_data;

  uart_frame_scheduler #(
    .NUM_CH (NUM_CH),
    .HEADER (8'hA5),
    .ID_W   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_data    (i_data),
    .o_ack     (o_ack),
    .o_busy    (o_busy),
    .i_tx_full (i_tx_full),
    .o_wr_uart (o_wr_uart),
    .o_w_data  (o_w_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe / ack recorder, sampled on the falling edge.
  logic [31:0] byte_q [$];
  int          bcyc_q [$];
  int          ack_cnt [NUM_CH];

  always @(negedge clk) begin
    if (o_wr_uart) begin
      byte_q.push_back(o_w_data);
      bcyc_q.push_back(cyc);
    end
    for (int k = 0; k < NUM_CH; k++)
      if (o_ack[k]) ack_cnt[k] = ack_cnt[k] + 1;
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Step to just after the falling edge so the recorder has already run.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rec();
    byte_q.delete();
    bcyc_q.delete();
    for (int k = 0; k < NUM_CH; k++) ack_cnt[k] = 0;
  endtask

  function automatic logic [7:0] exp_byte(input int ch, input logic [31:0] w, input int i);
    logic [7:0] s;
    case (i)
      0: return 8'hA5;
      1: return 8'(ch);
      2: return w[31:24];
      3: return w[23:16];
      4: return w[15:8];
      5: return w[7:0];
      default: begin
        s = 8'hA5 + 8'(ch) + w[31:24] + w[23:16] + w[15:8] + w[7:0];
        return s;
      end
    endcase
  endfunction

  task automatic check_frame(input string tag, input int base, input int ch,
                             input logic [31:0] w, input bit gaps);
    for (int i = 0; i < FLEN; i++) begin
      if (base + i < byte_q.size()) begin
        check($sformatf("%s_byte%0d", tag, i), byte_q[base+i], {24'h0, exp_byte(ch, w, i)});
        if (gaps && i > 0)
          check($sformatf("%s_gap%0d", tag, i), bcyc_q[base+i] - bcyc_q[base+i-1], 2);
      end
    end
  endtask

  task automatic wait_ack(input int ch, output int at);
    at = -1;
    for (int i = 0; i < 100; i++) begin
      if (o_ack[ch]) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) check($sformatf("ack%0d_timeout", ch), 0, 1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (!o_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
    repeat (3) tick();
  endtask

  task automatic wait_bytes(input int n);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (byte_q.size() >= n) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) check("bytes_timeout", byte_q.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  // Hold the given requests, dropping each one as soon as it is acked.
  task automatic serve(input logic [NUM_CH-1:0] mask);
    bit done;
    done  = 1'b0;
    i_req = mask;
    for (int i = 0; i < 400; i++) begin
      tick();
      for (int k = 0; k < NUM_CH; k++)
        if (o_ack[k]) i_req[k] = 1'b0;
      if (i_req == '0 && !o_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("serve_timeout", 0, 1);
    repeat (3) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int at;
    int c0;
    int cf;

    reset     = 1'b1;
    i_req     = '0;
    i_data    = '0;
    i_tx_full = 1'b0;
    clear_rec();
    repeat (3) tick();

    // Reset state
    check("rst_busy", o_busy, 0);
    check("rst_wr", o_wr_uart, 0);
    check("rst_wdata", o_w_data, 0);
    check("rst_ack", o_ack, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Single ch0 frame with latency and strobe spacing
    clear_rec();
    i_data[31:0] = 32'h12345678;
    i_req        = 2'b01;
    c0           = cyc;
    wait_ack(0, at);
    i_req = '0;
    check("t1_ack_lat", at, c0 + 1);
    wait_idle();
    check("t1_count", byte_q.size(), FLEN);
    if (byte_q.size() > 0) check("t1_first_strobe", bcyc_q[0], c0 + 2);
    check_frame("t1", 0, 0, 32'h12345678, 1'b1);
    check("t1_ack0", ack_cnt[0], 1);
    check("t1_ack1", ack_cnt[1], 0);
    check("t1_busy_end", o_busy, 0);

    // Round robin: both requesting after reset, then both again
    do_reset();
    clear_rec();
    i_data[31:0]  = 32'h01020304;
    i_data[63:32] = 32'hCAFEF00D;
    serve(2'b11);
    check("t3a_count", byte_q.size(), 2 * FLEN);
    check_frame("t3a_f0", 0, 0, 32'h01020304, 1'b1);
    check_frame("t3a_f1", FLEN, 1, 32'hCAFEF00D, 1'b1);
    check("t3a_ack0", ack_cnt[0], 1);
    check("t3a_ack1", ack_cnt[1], 1);
    clear_rec();
    serve(2'b11);
    check("t3b_count", byte_q.size(), 2 * FLEN);
    check_frame("t3b_f0", 0, 0, 32'h01020304, 1'b1);
    check_frame("t3b_f1", FLEN, 1, 32'hCAFEF00D, 1'b1);

    // FIFO full stall after the B3 strobe
    clear_rec();
    i_data[31:0] = 32'h89ABCDEF;
    i_req        = 2'b01;
    wait_ack(0, at);
    i_req = '0;
    wait_bytes(3);
    i_tx_full = 1'b1;
    repeat (10) tick();
    check("t4_stall_count", byte_q.size(), 3);
    check("t4_stall_busy", o_busy, 1);
    i_tx_full = 1'b0;
    cf        = cyc;
    wait_bytes(4);
    if (byte_q.size() >= 4) check("t4_resume_cyc", bcyc_q[3], cf + 1);
    wait_idle();
    check("t4_count", byte_q.size(), FLEN);
    check_frame("t4", 0, 0, 32'h89ABCDEF, 1'b0);

    // Reset after the B2 strobe with the request still held
    clear_rec();
    i_data[31:0] = 32'h0BADCAFE;
    i_req        = 2'b01;
    wait_bytes(4);
    reset = 1'b1;
    tick();
    check("t5_wr_after_rst", o_wr_uart, 0);
    check("t5_busy_after_rst", o_busy, 0);
    check("t5_pre_count", byte_q.size(), 4);
    reset = 1'b0;
    clear_rec();
    wait_ack(0, at);
    i_req = '0;
    wait_idle();
    check("t5_count", byte_q.size(), FLEN);
    check_frame("t5", 0, 0, 32'h0BADCAFE, 1'b1);
    check("t5_ack0", ack_cnt[0], 1);

    // Ch1 request raised and dropped while a frame is busy
    clear_rec();
    i_data[31:0]  = 32'h11223344;
    i_data[63:32] = 32'h55667788;
    i_req         = 2'b01;
    wait_ack(0, at);
    i_req = '0;
    repeat (2) tick();
    i_req = 2'b10;
    repeat (3) tick();
    check("t6_busy_at_drop", o_busy, 1);
    i_req = '0;
    wait_idle();
    repeat (5) tick();
    check("t6_ack1", ack_cnt[1], 0);
    check("t6_count", byte_q.size(), FLEN);
    check_frame("t6", 0, 0, 32'h11223344, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
